// File: rtl/mult_div_seq_if.sv
// Request/result bundle between the control unit and mult_div_seq.
// The control unit is the master; the engine is the slave.
interface mult_div_seq_if;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, div_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/mult_div_seq.sv
// Sequential 32-bit signed MULT (Booth radix-2) / DIV (restoring) engine.
// Define MULTDIV_DIVZERO_EXC_EN to short-circuit divide-by-zero with div_zero.
module mult_div_seq (
    input logic           clk,
    input logic           reset,
    mult_div_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        op_q, op_d;
    logic [32:0] m_q, m_d;
    logic [32:0] acc_q, acc_d;
    logic [31:0] qr_q, qr_d;
    logic        qm1_q, qm1_d;
    logic        a_neg_q, a_neg_d;
    logic        b_neg_q, b_neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic        dz_start;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] booth_sum;
    logic [32:0] r_sh;
    logic [32:0] trial;

    assign accept = bus.start &&
                    (state_q == S_IDLE || state_q == S_DONE);

`ifdef MULTDIV_DIVZERO_EXC_EN
    logic dz_q, dz_d;
    assign dz_start = accept && bus.op && (bus.b_in == 32'd0);
`else
    assign dz_start = 1'b0;
`endif

    assign a_mag = bus.a_in[31] ? (32'd0 - bus.a_in) : bus.a_in;
    assign b_mag = bus.b_in[31] ? (32'd0 - bus.b_in) : bus.b_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 1'b0;
            m_q     <= 33'd0;
            acc_q   <= 33'd0;
            qr_q    <= 32'd0;
            qm1_q   <= 1'b0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
`ifdef MULTDIV_DIVZERO_EXC_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            qm1_q   <= qm1_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULTDIV_DIVZERO_EXC_EN
            dz_q    <= dz_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (dz_start)
                        state_d = S_DONE;
                    else if (bus.op)
                        state_d = S_DIV;
                    else
                        state_d = S_MULT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MULT, S_DIV: begin
                if (cnt_q == 5'd31)
                    state_d = S_FIX;
            end
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        op_d      = op_q;
        m_d       = m_q;
        acc_d     = acc_q;
        qr_d      = qr_q;
        qm1_d     = qm1_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        booth_sum = acc_q;
        r_sh      = {acc_q[31:0], qr_q[31]};
        trial     = r_sh - m_q;
`ifdef MULTDIV_DIVZERO_EXC_EN
        dz_d      = dz_q;
`endif
        if (accept) begin
            op_d    = bus.op;
            cnt_d   = 5'd0;
            acc_d   = 33'd0;
            qm1_d   = 1'b0;
            a_neg_d = bus.a_in[31];
            b_neg_d = bus.b_in[31];
`ifdef MULTDIV_DIVZERO_EXC_EN
            dz_d    = dz_start;
`endif
            if (bus.op) begin
                m_d  = {1'b0, b_mag};
                qr_d = a_mag;
            end else begin
                m_d  = {bus.a_in[31], bus.a_in};
                qr_d = bus.b_in;
            end
        end else begin
            unique case (state_q)
                S_MULT: begin
                    unique case ({qr_q[0], qm1_q})
                        2'b01:   booth_sum = acc_q + m_q;
                        2'b10:   booth_sum = acc_q - m_q;
                        default: booth_sum = acc_q;
                    endcase
                    acc_d = {booth_sum[32], booth_sum[32:1]};
                    qr_d  = {booth_sum[0], qr_q[31:1]};
                    qm1_d = qr_q[0];
                    cnt_d = cnt_q + 5'd1;
                end
                S_DIV: begin
                    // Sign bit of the 33-bit trial tells us whether R >= |b|.
                    if (!trial[32]) begin
                        acc_d = trial;
                        qr_d  = {qr_q[30:0], 1'b1};
                    end else begin
                        acc_d = r_sh;
                        qr_d  = {qr_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 5'd1;
                end
                S_FIX: begin
                    if (op_q) begin
                        lo_d = (a_neg_q ^ b_neg_q) ? (32'd0 - qr_q) : qr_q;
                        hi_d = a_neg_q ? (32'd0 - acc_q[31:0])
                                       : acc_q[31:0];
                    end else begin
                        hi_d = acc_q[31:0];
                        lo_d = qr_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.busy   = (state_q == S_MULT) ||
                     (state_q == S_DIV)  ||
                     (state_q == S_FIX);
        bus.done   = (state_q == S_DONE);
`ifdef MULTDIV_DIVZERO_EXC_EN
        bus.div_zero = (state_q == S_DONE) && dz_q;
`else
        bus.div_zero = 1'b0;
`endif
        bus.hi_out = hi_q;
        bus.lo_out = lo_q;
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed + random bench for mult_div_seq with an expected-result queue.
// Honours MULTDIV_DIVZERO_EXC_EN for the divide-by-zero cases.
module tb_mult_div_seq;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    mult_div_seq_if bus ();

    mult_div_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t   e;
        longint p;
        int     sa;
        int     sb_;
        sa    = a;
        sb_   = b;
        e.dz  = 1'b0;
        e.lat = 34;
        if (!op) begin
            p    = longint'(sa) * longint'(sb_);
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
`ifdef MULTDIV_DIVZERO_EXC_EN
            e.hi  = prev_hi;
            e.lo  = prev_lo;
            e.dz  = 1'b1;
            e.lat = 1;
`else
            e.hi = a;
            e.lo = a[31] ? 32'h1 : 32'hFFFF_FFFF;
`endif
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.hi = 32'd0;
            e.lo = 32'h8000_0000;
        end else begin
            e.lo = sa / sb_;
            e.hi = sa % sb_;
        end
        return e;
    endfunction

    task automatic do_op(input logic op, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e);
        exp_t got;
        int   lat;
        int   nb;
        @(negedge clk);
        chk("idle_done_low", {31'd0, bus.done}, 32'd0);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = $urandom;
        bus.b_in  = $urandom;
        bus.op    = ~op;
        lat = 1;
        nb  = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            if (bus.busy === 1'b1) nb++;
            @(negedge clk);
            lat++;
        end
        got = sb.pop_front();
        chk("latency", lat, got.lat);
        chk("busy_cycles", nb, got.lat - 1);
        chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
        chk("hi", bus.hi_out, got.hi);
        chk("lo", bus.lo_out, got.lo);
        chk("div_zero", {31'd0, bus.div_zero}, {31'd0, got.dz});
        prev_hi = got.hi;
        prev_lo = got.lo;
    endtask

    function automatic exp_t mk(input logic [31:0] hi,
                                input logic [31:0] lo,
                                input logic dz, input int lat);
        exp_t e;
        e.hi  = hi;
        e.lo  = lo;
        e.dz  = dz;
        e.lat = lat;
        return e;
    endfunction

    initial begin
        logic        rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          saw_done;
        checks    = 0;
        errors    = 0;
        prev_hi   = 32'd0;
        prev_lo   = 32'd0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a_in  = 32'd0;
        bus.b_in  = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_dz", {31'd0, bus.div_zero}, 32'd0);
        chk("rst_hi", bus.hi_out, 32'd0);
        chk("rst_lo", bus.lo_out, 32'd0);

        do_op(1'b0, 32'd7, 32'hFFFF_FFFD,
              mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34));
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000,
              mk(32'h4000_0000, 32'h0, 1'b0, 34));
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2,
              mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34));
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
              mk(32'h0, 32'h8000_0000, 1'b0, 34));
        do_op(1'b1, 32'h451, 32'h20, mk(32'h11, 32'h22, 1'b0, 34));
`ifdef MULTDIV_DIVZERO_EXC_EN
        do_op(1'b1, 32'd5, 32'd0, mk(32'h11, 32'h22, 1'b1, 1));
`else
        do_op(1'b1, 32'd5, 32'd0, mk(32'd5, 32'hFFFF_FFFF, 1'b0, 34));
`endif
        do_op(1'b1, 32'hFFFF_FFF6, 32'd0, model(1'b1, 32'hFFFF_FFF6, 32'd0));
        do_op(1'b0, 32'h7FFF_FFFF, 32'h8000_0000,
              model(1'b0, 32'h7FFF_FFFF, 32'h8000_0000));
        do_op(1'b1, 32'd100, 32'hFFFF_FFF9,
              model(1'b1, 32'd100, 32'hFFFF_FFF9));

        for (int i = 0; i < 6; i++) begin
            rop = 1'(i % 2);
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : $urandom;
            do_op(rop, ra, rb, model(rop, ra, rb));
        end

        // Abort: start, ignored re-start at T+5, reset at T+10.
        saw_done = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a_in  = 32'd3;
        bus.b_in  = 32'd4;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start = (c == 5);
            reset     = (c == 10);
            if (bus.done === 1'b1) saw_done++;
            if (c == 5) chk("busy_t5", {31'd0, bus.busy}, 32'd1);
        end
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_hi", bus.hi_out, 32'd0);
        chk("abort_lo", bus.lo_out, 32'd0);
        chk("abort_no_done", saw_done, 32'd0);
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        do_op(1'b0, 32'hFFFF_FFFE, 32'd9,
              mk(32'hFFFF_FFFF, 32'hFFFF_FFEE, 1'b0, 34));

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
